uart_rx_os: RTL and testbench

//  Oversampling UART receiver: the far end of the serial line driven by the transmitter.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx_os.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_os.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and the 2-of-3 vote.
// Used by both the receiver and the matching transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } rx_state_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line conditioner: 2-flop synchroniser, 3-sample history, falling-edge detect and majority vote.
// Latency: rx_s lags the pad by 2 clocks and the vote by 3-5 clocks; no backpressure, free-running.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_datain,
  output logic o_rx_s,
  output logic o_fall,
  output logic o_vote
);

  logic       meta_q;
  logic       rx_s_q;
  logic [2:0] hist_q;

  // Everything resets to the idle (high) line level so reset never fakes a start edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      hist_q <= 3'b111;
    end else begin
      meta_q <= i_datain;
      rx_s_q <= meta_q;
      hist_q <= {hist_q[1:0], rx_s_q};
    end
  end

  assign o_rx_s = rx_s_q;
  assign o_fall = hist_q[0] & ~rx_s_q;
  assign o_vote = maj3(hist_q);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1/8E1/8O1 UART receiver: start validation, mid-bit voting, framing/parity checks.
// Latency: o_valid 3+HALF+(9+PARITY_EN)*CLKS_PER_BIT clocks after the line falls; no backpressure, pulses are not held.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_datain,
  output logic [7:0] o_dataout,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);
  localparam logic           ODD      = (PARITY_ODD != 0);
  localparam logic           HAS_PAR  = (PARITY_EN != 0);

  logic rx_s;
  logic fall;
  logic vote;

  uart_rx_sync u_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_datain (i_datain),
    .o_rx_s   (rx_s),
    .o_fall   (fall),
    .o_vote   (vote)
  );

  rx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic [7:0]    dataout_q, dataout_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          perr_q, perr_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    dataout_d = dataout_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        baud_d    = '0;
        idx_d     = '0;
        par_err_d = 1'b0;
        if (fall) begin
          state_d = S_START;
        end
      end

      // A start bit that is high again by mid-bit was a glitch.
      S_START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          state_d = vote ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      S_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = {vote, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      S_PARITY: begin
        if (baud_q == BIT_LAST) begin
          baud_d    = '0;
          par_err_d = ((^shift_q) ^ vote) != ODD;
          state_d   = S_STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      S_STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (vote) begin
            dataout_d = shift_q;
            valid_d   = 1'b1;
            perr_d    = par_err_q;
            state_d   = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      // A line held low (break) must return high before another start is accepted.
      S_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_dataout    = dataout_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 and an 8E1 receiver driven by a bit-level line driver,
// checked by a frame-level scoreboard (byte, error flags, pulse cycle).
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int CPB  = 10;
  localparam int HALF = CPB / 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       line0 = 1'b1;
  logic       line1 = 1'b1;
  logic [7:0] dout0, dout1;
  logic       v0, v1, fe0, fe1, pe0, pe1, b0, b1;

  uart_rx_os #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_datain(line0), .o_dataout(dout0),
    .o_valid(v0), .o_frame_err(fe0), .o_parity_err(pe0), .o_busy(b0)
  );

  uart_rx_os #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_datain(line1), .o_dataout(dout1),
    .o_valid(v1), .o_frame_err(fe1), .o_parity_err(pe1), .o_busy(b1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         ferr;
    int         cyc;
    logic [7:0] data;
    bit         perr;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] last0 = 8'h00;
  logic [7:0] last1 = 8'h00;
  bit         busy_seen = 1'b0;

  // Frame-level reference: outcome and pulse cycle of a frame whose start edge is in cycle t0.
  function automatic exp_t model(input logic [7:0] b, input bit pe, input logic p,
                                 input logic stop, input int t0);
    exp_t e;
    e.ferr = !stop;
    e.data = b;
    e.perr = pe && stop && (($countones({b, p}) % 2) != 0);
    e.cyc  = t0 + 2 + HALF + (pe ? 10 : 9) * CPB + 1;
    return e;
  endfunction

  task automatic mon(input int sel, input logic v, input logic fe, input logic pe,
                     input logic [7:0] d);
    exp_t  e;
    string tag;
    tag = (sel == 0) ? "rx0" : "rx1";
    if (!(v || fe || pe)) return;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      chk({tag, " unexpected pulse v/fe/pe"}, {29'd0, v, fe, pe}, 32'd0);
      return;
    end
    if (sel == 0) e = q0.pop_front();
    else          e = q1.pop_front();
    chk({tag, " pulse cycle"}, cyc, e.cyc);
    chk({tag, " valid"}, v, !e.ferr);
    chk({tag, " frame_err"}, fe, e.ferr);
    chk({tag, " parity_err"}, pe, e.perr);
    if (!e.ferr) begin
      chk({tag, " dataout"}, d, e.data);
      if (sel == 0) last0 = e.data;
      else          last1 = e.data;
    end else begin
      chk({tag, " dataout held"}, d, (sel == 0) ? last0 : last1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, v0, fe0, pe0, dout0);
      mon(1, v1, fe1, pe1, dout1);
      if (b0) busy_seen = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int sel, input logic val);
    if (sel == 0) line0 = val;
    else          line1 = val;
  endtask

  // flip = offset within the bit where the line is inverted for one clock (-1 = none).
  task automatic drive_bit(input int sel, input logic val, input int flip);
    for (int i = 0; i < CPB; i++) begin
      set_line(sel, (i == flip) ? ~val : val);
      tick();
    end
  endtask

  task automatic idle(input int sel, input int n);
    set_line(sel, 1'b1);
    repeat (n) tick();
  endtask

  task automatic send(input int sel, input logic [7:0] b, input bit pe, input logic p,
                      input logic stop, input int flip);
    drive_bit(sel, 1'b0, flip);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i], flip);
    if (pe) drive_bit(sel, p, flip);
    drive_bit(sel, stop, flip);
  endtask

  task automatic send_exp(input int sel, input logic [7:0] b, input bit pe, input logic p,
                          input logic stop, input int flip);
    exp_t e;
    e = model(b, pe, p, stop, cyc);
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
    send(sel, b, pe, p, stop, flip);
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 400) begin
      tick();
      n++;
    end
    chk((sel == 0) ? "rx0 all frames seen" : "rx1 all frames seen",
        (sel == 0) ? q0.size() : q1.size(), 0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         flip;
    int         gap;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] b9;
    vecs[0] = '{8'h95, 1'b1, -1,  0, 1'b1, 8'h95};
    vecs[1] = '{8'hB9, 1'b1, -1,  5, 1'b1, 8'hB9};
    vecs[2] = '{8'h00, 1'b1, -1,  0, 1'b1, 8'h00};
    vecs[3] = '{8'hFF, 1'b1,  3,  2, 1'b1, 8'hFF};
    vecs[4] = '{8'h95, 1'b1, -1,  3, 1'b1, 8'h95};
    vecs[5] = '{8'hC3, 1'b0, -1, 15, 1'b0, 8'h95};
    vecs[6] = '{8'h80, 1'b1, -1,  0, 1'b1, 8'h80};
    vecs[7] = '{8'h01, 1'b1,  3,  4, 1'b1, 8'h01};

    // Reset state
    repeat (3) tick();
    chk("reset dout0", dout0, 8'h00);
    chk("reset valid0", v0, 0);
    chk("reset ferr0", fe0, 0);
    chk("reset perr0", pe0, 0);
    chk("reset busy0", b0, 0);
    chk("reset dout1", dout1, 8'h00);
    chk("reset busy1", b1, 0);
    rst = 1'b0;
    idle(0, 10);

    // Table of frames on the 8N1 receiver
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.ferr = !vecs[i].exp_valid;
      e.data = vecs[i].exp_data;
      e.perr = 1'b0;
      e.cyc  = cyc + 2 + HALF + 9 * CPB + 1;
      q0.push_back(e);
      send(0, vecs[i].b, 1'b0, 1'b0, vecs[i].stop, vecs[i].flip);
      idle(0, vecs[i].gap);
      if (!vecs[i].exp_valid) begin
        chk("table dataout after bad stop", dout0, vecs[i].exp_data);
      end
    end
    idle(0, 5);
    drain(0);

    // Short low glitch on an idle line
    busy_seen = 1'b0;
    set_line(0, 1'b0);
    repeat (3) tick();
    set_line(0, 1'b1);
    repeat (HALF + 3) tick();
    chk("glitch started a frame", busy_seen, 1);
    chk("glitch busy cleared", b0, 0);
    idle(0, 10);

    // Bad stop bit, line held low afterwards, then recovery
    send_exp(0, 8'h95, 1'b0, 1'b0, 1'b1, -1);
    idle(0, 3);
    send_exp(0, 8'hC3, 1'b0, 1'b0, 1'b0, -1);
    set_line(0, 1'b0);
    repeat (30) tick();
    drain(0);
    chk("frame err keeps dataout", dout0, 8'h95);
    chk("stuck-low line keeps busy", b0, 1);
    idle(0, 6);
    chk("line high releases busy", b0, 0);
    send_exp(0, 8'hCC, 1'b0, 1'b0, 1'b1, -1);
    idle(0, 3);
    drain(0);

    // Even parity receiver
    send_exp(1, 8'hCC, 1'b1, 1'b1, 1'b1, -1);
    idle(1, 3);
    send_exp(1, 8'hCC, 1'b1, 1'b0, 1'b1, -1);
    idle(1, 3);
    drain(1);
    chk("parity rx dataout", dout1, 8'hCC);

    // Reset during bit 4 of 0xB9
    b9 = 8'hB9;
    drive_bit(0, 1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(0, b9[i], -1);
    set_line(0, b9[4]);
    repeat (5) tick();
    rst   = 1'b1;
    line0 = 1'b1;
    tick();
    chk("mid-frame reset dout0", dout0, 8'h00);
    chk("mid-frame reset valid0", v0, 0);
    chk("mid-frame reset ferr0", fe0, 0);
    chk("mid-frame reset busy0", b0, 0);
    chk("mid-frame reset dout1", dout1, 8'h00);
    rst   = 1'b0;
    last0 = 8'h00;
    last1 = 8'h00;
    idle(0, 20);
    send_exp(0, 8'h95, 1'b0, 1'b0, 1'b1, -1);
    idle(0, 3);
    drain(0);

    // Four back-to-back frames with a one-clock flip inside every bit
    for (int k = 0; k < 4; k++) send_exp(0, 8'hA5, 1'b0, 1'b0, 1'b1, 3);
    idle(0, 3);
    drain(0);

    // Random frames on both receivers
    for (int k = 0; k < 20; k++) begin
      logic [7:0] rb;
      logic       rstop;
      int         rflip;
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 5) != 0);
      rflip = ($urandom_range(0, 1) != 0) ? 3 : -1;
      send_exp(0, rb, 1'b0, 1'b0, rstop, rflip);
      idle(0, rstop ? $urandom_range(0, 12) : 12 + $urandom_range(0, 5));
    end
    idle(0, 3);
    drain(0);
    for (int k = 0; k < 12; k++) begin
      logic [7:0] rb;
      logic       rp;
      logic       rstop;
      rb    = 8'($urandom_range(0, 255));
      rp    = 1'($urandom_range(0, 1));
      rstop = ($urandom_range(0, 5) != 0);
      send_exp(1, rb, 1'b1, rp, rstop, ($urandom_range(0, 1) != 0) ? 3 : -1);
      idle(1, rstop ? $urandom_range(0, 8) : 12 + $urandom_range(0, 5));
    end
    idle(1, 3);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
